alu_sched: RTL and testbench

Round-robin scheduler sharing one 4-bit ALU between two requesters. Each requester submits an opcode and two 4-bit operands over a valid/ready handshake. The scheduler grants one request at a time, executes it on an internal ALU core and returns the result, flags and requester ID over a held response port. It sits between the switch/button front end (or a test master) and the 7-segment display path, in place of direct switch-to-ALU wiring.

---
 rtl/alu_pkg.sv | 36 +++
 rtl/alu_core.sv | 86 ++++++++
 rtl/alu_sched.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu_sched.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the round-robin ALU scheduler.
//   ALU_W            default operand/result width
//   ALU_ADD..ALU_EQ  3-bit opcode encodings understood by alu_core
//   state_e          scheduler FSM states (IDLE, EXEC, RESP)
//   id_onehot        requester index -> one-hot 2-bit ready/grant vector
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOT = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  function automatic logic [1:0] id_onehot(input logic id);
    logic [1:0] oh;
    oh = 2'b00;
    if (id) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational W-bit ALU, the single shared resource
// behind alu_sched.
//   op      in  3  opcode (see alu_pkg)
//   a, b    in  W  operands, two's complement where signedness matters
//   result  out W  ALU result (compare ops return 0 or 1)
//   carry   out 1  adder carry-out, add/sub only
//   ovf     out 1  signed overflow, add/sub only
//   zero    out 1  result == 0, all ops
module alu_core
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         ovf,
  output logic         zero
);

  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO = {W{1'b0}};

  logic [W:0] add_s;
  logic [W:0] sub_s;
  logic       add_ovf_s;
  logic       sub_ovf_s;
  logic       slt_s;

  // Subtraction reuses the adder form a + ~b + 1 so carry means "no borrow".
  assign add_s = {1'b0, a} + {1'b0, b};
  assign sub_s = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};

  // Overflow: effective operand signs agree but the result sign differs.
  assign add_ovf_s = (a[W-1] == b[W-1]) && (add_s[W-1] != a[W-1]);
  assign sub_ovf_s = (a[W-1] != b[W-1]) && (sub_s[W-1] != a[W-1]);
  assign slt_s     = ($signed(a) < $signed(b));

  // Opcode decode; carry/ovf stay low for every non-arithmetic op.
  always_comb begin
    result = ZERO;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = add_s[W-1:0];
        carry  = add_s[W];
        ovf    = add_ovf_s;
      end
      ALU_SUB: begin
        result = sub_s[W-1:0];
        carry  = sub_s[W];
        ovf    = sub_ovf_s;
      end
      ALU_NOT: result = ~a;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: begin
        if (slt_s) begin
          result = ONE;
        end else begin
          result = ZERO;
        end
      end
      ALU_EQ: begin
        if (a == b) begin
          result = ONE;
        end else begin
          result = ZERO;
        end
      end
      default: begin
        result = ZERO;
        carry  = 1'b0;
        ovf    = 1'b0;
      end
    endcase
  end

  // Zero flag derived from the selected result.
  assign zero = (result == ZERO);

endmodule

// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler sharing one alu_core between two
// requesters over valid/ready, returning a held response.
//   clk, rst          clock (rising) / async active-low reset
//   req_valid/ready   2-bit per-requester handshake, bit i = requester i
//   req_op0/1, req_a0/b0/a1/b1   opcode and operands per requester
//   rsp_valid/ready   response handshake; rsp_* held while rsp_ready=0
//   rsp_id            requester index of the response
//   rsp_result, rsp_carry, rsp_ovf, rsp_zero   ALU result and flags
// Optional feature macro ALU_SCHED_STATS_EN adds stat_cnt0/stat_cnt1,
// 8-bit wrapping counters of accepted requests per requester.
module alu_sched
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [2:0]   req_op0,
  input  logic [2:0]   req_op1,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_ovf,
  output logic         rsp_zero
`ifdef ALU_SCHED_STATS_EN
  ,
  output logic [7:0]   stat_cnt0,
  output logic [7:0]   stat_cnt1
`endif
);

  state_e       state_q, state_d;
  logic         prio_q, prio_d;
  logic [2:0]   cmd_op_q, cmd_op_d;
  logic [W-1:0] cmd_a_q, cmd_a_d;
  logic [W-1:0] cmd_b_q, cmd_b_d;
  logic         cmd_id_q, cmd_id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_id_q, rsp_id_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_carry_q, rsp_carry_d;
  logic         rsp_ovf_q, rsp_ovf_d;
  logic         rsp_zero_q, rsp_zero_d;

  logic         gnt_vld_s;
  logic         gnt_id_s;
  logic         accept_s;
  logic [2:0]   sel_op_s;
  logic [W-1:0] sel_a_s;
  logic [W-1:0] sel_b_s;
  logic [W-1:0] alu_result_s;
  logic         alu_carry_s;
  logic         alu_ovf_s;
  logic         alu_zero_s;

  // Arbitration: a lone requester wins; on contention prio picks the winner.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    case (req_valid)
      2'b01: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b0;
      end
      2'b10: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = 1'b1;
      end
      2'b11: begin
        gnt_vld_s = 1'b1;
        gnt_id_s  = prio_q;
      end
      default: begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
      end
    endcase
  end

  // Ready only toward the granted requester, and only while idle.
  always_comb begin
    req_ready = 2'b00;
    if ((state_q == IDLE) && gnt_vld_s) begin
      req_ready = id_onehot(gnt_id_s);
    end else begin
      req_ready = 2'b00;
    end
  end

  assign accept_s = (state_q == IDLE) && gnt_vld_s;

  // Command source mux for the granted requester.
  always_comb begin
    sel_op_s = req_op0;
    sel_a_s  = req_a0;
    sel_b_s  = req_b0;
    if (gnt_id_s) begin
      sel_op_s = req_op1;
      sel_a_s  = req_a1;
      sel_b_s  = req_b1;
    end else begin
      sel_op_s = req_op0;
      sel_a_s  = req_a0;
      sel_b_s  = req_b0;
    end
  end

  alu_core #(.W(W)) u_alu_core (
    .op     (cmd_op_q),
    .a      (cmd_a_q),
    .b      (cmd_b_q),
    .result (alu_result_s),
    .carry  (alu_carry_s),
    .ovf    (alu_ovf_s),
    .zero   (alu_zero_s)
  );

  // FSM next-state: latch command on accept, capture ALU in EXEC, hold in RESP.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    cmd_op_d     = cmd_op_q;
    cmd_a_d      = cmd_a_q;
    cmd_b_d      = cmd_b_q;
    cmd_id_d     = cmd_id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          cmd_op_d = sel_op_s;
          cmd_a_d  = sel_a_s;
          cmd_b_d  = sel_b_s;
          cmd_id_d = gnt_id_s;
          prio_d   = ~gnt_id_s;
          state_d  = EXEC;
        end else begin
          state_d  = IDLE;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result_s;
        rsp_carry_d  = alu_carry_s;
        rsp_ovf_d    = alu_ovf_s;
        rsp_zero_d   = alu_zero_s;
        rsp_id_d     = cmd_id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // Leaving RESP drops only valid; the payload stays put.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State, command and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      cmd_op_q     <= 3'b000;
      cmd_a_q      <= {W{1'b0}};
      cmd_b_q      <= {W{1'b0}};
      cmd_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {W{1'b0}};
      rsp_carry_q  <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      cmd_op_q     <= cmd_op_d;
      cmd_a_q      <= cmd_a_d;
      cmd_b_q      <= cmd_b_d;
      cmd_id_q     <= cmd_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_zero   = rsp_zero_q;

`ifdef ALU_SCHED_STATS_EN
  logic [7:0] stat_cnt0_q, stat_cnt0_d;
  logic [7:0] stat_cnt1_q, stat_cnt1_d;

  // Per-requester accept counters; plain 8-bit add wraps 255 -> 0.
  always_comb begin
    stat_cnt0_d = stat_cnt0_q;
    stat_cnt1_d = stat_cnt1_q;
    if (accept_s && !gnt_id_s) begin
      stat_cnt0_d = stat_cnt0_q + 8'd1;
    end else if (accept_s && gnt_id_s) begin
      stat_cnt1_d = stat_cnt1_q + 8'd1;
    end else begin
      stat_cnt0_d = stat_cnt0_q;
      stat_cnt1_d = stat_cnt1_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cnt0_q <= 8'd0;
      stat_cnt1_q <= 8'd0;
    end else begin
      stat_cnt0_q <= stat_cnt0_d;
      stat_cnt1_q <= stat_cnt1_d;
    end
  end

  assign stat_cnt0 = stat_cnt0_q;
  assign stat_cnt1 = stat_cnt1_q;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: scoreboard of expected responses,
// one task per scenario, summary line at the end.
module tb_alu_sched;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [2:0] req_op0, req_op1;
  logic [3:0] req_a0, req_b0, req_a1, req_b1;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_carry, rsp_ovf, rsp_zero;
`ifdef ALU_SCHED_STATS_EN
  logic [7:0] stat_cnt0, stat_cnt1;
`endif

  typedef struct packed {
    logic       id;
    logic [3:0] res;
    logic       c;
    logic       v;
    logic       z;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   failures;

  alu_sched #(.W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op0    (req_op0),
    .req_op1    (req_op1),
    .req_a0     (req_a0),
    .req_b0     (req_b0),
    .req_a1     (req_a1),
    .req_b1     (req_b1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ovf    (rsp_ovf),
    .rsp_zero   (rsp_zero)
`ifdef ALU_SCHED_STATS_EN
    ,
    .stat_cnt0  (stat_cnt0),
    .stat_cnt1  (stat_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Reference ALU built on integer arithmetic.
  function automatic exp_t model(input logic id, input logic [2:0] op,
                                 input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    int ua, ub, sa, sb, t;
    ua = int'(a);
    ub = int'(b);
    sa = a[3] ? ua - 16 : ua;
    sb = b[3] ? ub - 16 : ub;
    e.id = id;
    e.c = 1'b0;
    e.v = 1'b0;
    e.res = 4'd0;
    case (op)
      3'd0: begin
        t = ua + ub;
        e.res = t[3:0];
        e.c = (t > 15);
        e.v = ((sa + sb) > 7) || ((sa + sb) < -8);
      end
      3'd1: begin
        t = ua - ub;
        e.res = t[3:0];
        e.c = (ua >= ub);
        e.v = ((sa - sb) > 7) || ((sa - sb) < -8);
      end
      3'd2: e.res = ~a;
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = a ^ b;
      3'd6: e.res = (sa < sb) ? 4'd1 : 4'd0;
      3'd7: e.res = (a == b) ? 4'd1 : 4'd0;
      default: e.res = 4'd0;
    endcase
    e.z = (e.res == 4'd0);
    return e;
  endfunction

  task automatic set_req(input logic id, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b);
    if (id == 1'b0) begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_valid[0] = 1'b1;
    end else begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_valid[1] = 1'b1;
    end
  endtask

  // Scoreboard consumer: pop the oldest expectation and compare the response.
  task automatic sb_pop_compare(input string tag);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $display("FAIL %s: response with empty scoreboard id=%0d result=%h", tag, rsp_id, rsp_result);
    end else begin
      e = sbq.pop_front();
      if ({rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero} !== {e.id, e.res, e.c, e.v, e.z}) begin
        failures++;
        $display("FAIL %s: got id=%0d res=%h c=%0d v=%0d z=%0d want id=%0d res=%h c=%0d v=%0d z=%0d",
                 tag, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero, e.id, e.res, e.c, e.v, e.z);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One request from one requester, with latency checks.
  task automatic run_one(input logic id, input logic [2:0] op,
                         input logic [3:0] a, input logic [3:0] b, input string tag);
    int n;
    @(negedge clk);
    set_req(id, op, a, b);
    sbq.push_back(model(id, op, a, b));
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    checks++;
    if (!req_ready[id]) begin
      failures++;
      $display("FAIL %s_accept: req_ready=%b never granted requester %0d", tag, req_ready, id);
      req_valid[id] = 1'b0;
      void'(sbq.pop_back());
    end else begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
        failures++;
        $display("FAIL %s_exec: rsp_valid=%b req_ready=%b want 0 and 00", tag, rsp_valid, req_ready);
      end
      req_valid[id] = 1'b0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL %s_latency: rsp_valid=%b want 1", tag, rsp_valid);
      end
      sb_pop_compare(tag);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero} !== 9'd0) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b id=%b res=%h c=%b o=%b z=%b want all 0",
               rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_add_sub();
    run_one(1'b0, ALU_ADD, 4'b0111, 4'b0001, "add_7p1");
    run_one(1'b1, ALU_SUB, 4'b0011, 4'b0011, "sub_3m3");
  endtask

  task automatic test_ops();
    logic [3:0] pa [4];
    logic [3:0] pb [4];
    pa[0] = 4'b1000; pb[0] = 4'b0001;
    pa[1] = 4'b1010; pb[1] = 4'b1010;
    pa[2] = 4'b1111; pb[2] = 4'b0001;
    pa[3] = 4'b0000; pb[3] = 4'b0000;
    for (int op = 0; op < 8; op++) begin
      for (int p = 0; p < 4; p++) begin
        run_one(p[0], op[2:0], pa[p], pb[p], "ops_dir");
      end
    end
    for (int k = 0; k < 8; k++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      run_one(k[0], 3'($urandom_range(0, 7)), ra, rb, "ops_rand");
    end
  endtask

  task automatic test_back_to_back();
    int last_acc, cyc, got;
    logic exp_next;
    rst = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    set_req(1'b0, ALU_ADD, 4'd1, 4'd2);
    set_req(1'b1, ALU_XOR, 4'd5, 4'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    last_acc = -1;
    exp_next = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 40) begin
      if (req_ready != 2'b00) begin
        checks++;
        if (req_ready !== (exp_next ? 2'b10 : 2'b01)) begin
          failures++;
          $display("FAIL b2b_grant: req_ready=%b want grant to %0d", req_ready, exp_next);
        end
        if (last_acc >= 0) begin
          checks++;
          if (cyc - last_acc != 3) begin
            failures++;
            $display("FAIL b2b_spacing: accept gap %0d want 3", cyc - last_acc);
          end
        end
        if (exp_next)
          sbq.push_back(model(1'b1, ALU_XOR, 4'd5, 4'd3));
        else
          sbq.push_back(model(1'b0, ALU_ADD, 4'd1, 4'd2));
        last_acc = cyc;
        exp_next = ~exp_next;
      end
      if (rsp_valid) begin
        sb_pop_compare("b2b_rsp");
        got++;
      end
      if (got < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 2'b00;
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL b2b_timeout: got %0d responses want 4", got);
    end
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    exp_t e;
    int n;
    @(negedge clk);
    e = model(1'b0, ALU_ADD, 4'd2, 4'd3);
    set_req(1'b0, ALU_ADD, 4'd2, 4'd3);
    sbq.push_back(e);
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    rsp_ready = 1'b0;
    @(negedge clk);
    req_valid[0] = 1'b0;
    set_req(1'b1, ALU_XOR, 4'd6, 4'd3);
    sbq.push_back(model(1'b1, ALU_XOR, 4'd6, 4'd3));
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_first: rsp_valid=%b want 1", rsp_valid);
    end
    sb_pop_compare("bp_rsp0");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero} !== {1'b1, e.id, e.res, e.c, e.v, e.z}) begin
        failures++;
        $display("FAIL bp_hold: cycle %0d v=%b id=%b res=%h want v=1 id=%b res=%h", k, rsp_valid, rsp_id, rsp_result, e.id, e.res);
      end
      checks++;
      if (req_ready !== 2'b00) begin
        failures++;
        $display("FAIL bp_ready: cycle %0d req_ready=%b want 00", k, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b10 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: req_ready=%b rsp_valid=%b want 10 and 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_latency: rsp_valid=%b want 1", rsp_valid);
    end
    sb_pop_compare("bp_rsp1");
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    @(negedge clk);
    set_req(1'b0, ALU_ADD, 4'd4, 4'd4);
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_ovf, rsp_zero, req_ready} !== 11'd0) begin
      failures++;
      $display("FAIL rstmid_outputs: v=%b id=%b res=%h ready=%b want all 0", rsp_valid, rsp_id, rsp_result, req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_norsp: cycle %0d rsp_valid=%b want 0", k, rsp_valid);
      end
    end
    set_req(1'b0, ALU_SUB, 4'd9, 4'd2);
    set_req(1'b1, ALU_AND, 4'd7, 4'd5);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      failures++;
      $display("FAIL rstmid_prio: req_ready=%b want 01", req_ready);
    end
    sbq.push_back(model(1'b0, ALU_SUB, 4'd9, 4'd2));
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    sb_pop_compare("rstmid_rsp");
    @(negedge clk);
  endtask

`ifdef ALU_SCHED_STATS_EN
  task automatic test_stats();
    do_reset();
    checks++;
    if (stat_cnt0 !== 8'd0 || stat_cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL stats_reset: cnt0=%0d cnt1=%0d want 0 0", stat_cnt0, stat_cnt1);
    end
    for (int i = 0; i < 300; i++) begin
      run_one(1'b0, ALU_ADD, i[3:0], 4'd1, "stats_run");
    end
    @(negedge clk);
    checks++;
    if (stat_cnt0 !== 8'd44 || stat_cnt1 !== 8'd0) begin
      failures++;
      $display("FAIL stats_wrap: cnt0=%0d cnt1=%0d want 44 0", stat_cnt0, stat_cnt1);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req_op0 = 3'd0; req_op1 = 3'd0;
    req_a0 = 4'd0; req_b0 = 4'd0; req_a1 = 4'd0; req_b1 = 4'd0;
    test_reset();
    test_add_sub();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ALU_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
